// File: rtl/vdp_video_timing.sv
// Raster timing generator for the VDP display path: registered sync/blank, scaled
// window source coordinates, and sticky line/vblank interrupt flags.
module vdp_video_timing #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int SCALE           = 2,
  parameter int WIN_X0          = 64,
  parameter int WIN_Y0          = 48,
  parameter int WIN_W           = 256,
  parameter int WIN_H           = 192,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en_i,
  input  logic [7:0]    line_reload_i,
  input  logic          line_irq_ack_i,
  input  logic          vblank_irq_ack_i,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          blank_o,
  output logic          src_valid_o,
  output logic [8:0]    src_x_o,
  output logic [8:0]    src_y_o,
  output logic          line_irq_o,
  output logic          vblank_irq_o,
  output logic          frame_start_o
);

  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;
  localparam int WX_LIM = WIN_X0 + WIN_W * SCALE;
  localparam int WY_LIM = WIN_Y0 + WIN_H * SCALE;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] WX_BEG = HW'(WIN_X0);
  localparam logic [VW-1:0] WY_BEG = VW'(WIN_Y0);
  localparam logic [HW-1:0] WX_END = HW'(WX_LIM);
  localparam logic [VW-1:0] WY_END = VW'(WY_LIM);
  localparam logic [1:0]    SUB_LAST = 2'(SCALE - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  logic [8:0]    x_q, x_d, y_q, y_d;
  logic [7:0]    line_cnt_q, line_cnt_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
  logic          src_valid_q, src_valid_d;
  logic [8:0]    src_x_q, src_x_d, src_y_q, src_y_d;
  logic          line_irq_q, line_irq_d, vblank_irq_q, vblank_irq_d;
  logic          frame_start_q, frame_start_d;
  logic          h_wrap, in_h, in_v, blank_n, valid_n;

  // Every decode uses the next-state counters so outputs line up with h_cnt/v_cnt.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    sub_x_d       = sub_x_q;
    x_d           = x_q;
    sub_y_d       = sub_y_q;
    y_d           = y_q;
    line_cnt_d    = line_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    src_valid_d   = src_valid_q;
    src_x_d       = src_x_q;
    src_y_d       = src_y_q;
    line_irq_d    = line_irq_q & ~line_irq_ack_i;
    vblank_irq_d  = vblank_irq_q & ~vblank_irq_ack_i;
    frame_start_d = 1'b0;
    h_wrap        = (h_q == H_LAST);
    in_h          = 1'b0;
    in_v          = 1'b0;
    blank_n       = 1'b0;
    valid_n       = 1'b0;

    if (pix_en_i) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;

      in_h    = (int'(h_d) >= WIN_X0) && (int'(h_d) < WX_LIM);
      in_v    = (int'(v_d) >= WIN_Y0) && (int'(v_d) < WY_LIM);
      blank_n = (int'(h_d) >= H_ACTIVE) || (int'(v_d) >= V_ACTIVE);
      valid_n = in_h && in_v && !blank_n;

      hsync_d = ((int'(h_d) >= HS_BEG) && (int'(h_d) < HS_END)) ^ SYNC_ACTIVE_LOW;
      vsync_d = ((int'(v_d) >= VS_BEG) && (int'(v_d) < VS_END)) ^ SYNC_ACTIVE_LOW;
      blank_d = blank_n;

      if (!in_h || h_d == WX_BEG) begin
        sub_x_d = '0;
        x_d     = '0;
      end else if (sub_x_q == SUB_LAST) begin
        sub_x_d = '0;
        x_d     = x_q + 9'd1;
      end else begin
        sub_x_d = sub_x_q + 2'd1;
      end

      // Row replication only steps when the line advances.
      if (h_wrap) begin
        if (!in_v || v_d == WY_BEG) begin
          sub_y_d = '0;
          y_d     = '0;
        end else if (sub_y_q == SUB_LAST) begin
          sub_y_d = '0;
          y_d     = y_q + 9'd1;
        end else begin
          sub_y_d = sub_y_q + 2'd1;
        end
      end

      src_valid_d = valid_n;
      src_x_d     = valid_n ? x_d : '0;
      src_y_d     = valid_n ? y_d : '0;

      if (h_d == WX_END) begin
        if (!in_v) begin
          line_cnt_d = line_reload_i;
        end else if (sub_y_q == SUB_LAST) begin
          if (line_cnt_q == 8'd0) begin
            line_cnt_d = line_reload_i;
            line_irq_d = 1'b1;
          end else begin
            line_cnt_d = line_cnt_q - 8'd1;
          end
        end
        if (v_d == WY_END) vblank_irq_d = 1'b1;
      end

      frame_start_d = (h_d == '0) && (v_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      sub_x_q       <= '0;
      x_q           <= '0;
      sub_y_q       <= '0;
      y_q           <= '0;
      line_cnt_q    <= 8'hFF;
      hsync_q       <= SYNC_ACTIVE_LOW;
      vsync_q       <= SYNC_ACTIVE_LOW;
      blank_q       <= 1'b0;
      src_valid_q   <= 1'b0;
      src_x_q       <= '0;
      src_y_q       <= '0;
      line_irq_q    <= 1'b0;
      vblank_irq_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      sub_x_q       <= sub_x_d;
      x_q           <= x_d;
      sub_y_q       <= sub_y_d;
      y_q           <= y_d;
      line_cnt_q    <= line_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      src_valid_q   <= src_valid_d;
      src_x_q       <= src_x_d;
      src_y_q       <= src_y_d;
      line_irq_q    <= line_irq_d;
      vblank_irq_q  <= vblank_irq_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_cnt_o       = h_q;
  assign v_cnt_o       = v_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign blank_o       = blank_q;
  assign src_valid_o   = src_valid_q;
  assign src_x_o       = src_x_q;
  assign src_y_o       = src_y_q;
  assign line_irq_o    = line_irq_q;
  assign vblank_irq_o  = vblank_irq_q;
  assign frame_start_o = frame_start_q;

endmodule
